// File: rtl/div_seq_pkg.sv
// Shared types and op-decoding helpers for the M-extension divide sequencer.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } div_state_e;

  function automatic logic is_signed(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/response handshake between the execute stage (master) and the divide sequencer (slave).
interface div_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();
  import div_seq_pkg::*;

  logic             req_valid;
  logic             req_ready;
  div_op_e          req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             kill;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, kill, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, kill, resp_ready,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/divu_int.sv
// Unsigned restoring divider: one quotient bit per cycle, done pulses WIDTH cycles after start.
module divu_int #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic             valid_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic [WIDTH:0]   shifted, diff;

  // One extra bit so the shifted partial remainder never overflows before the compare.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    if (start_i) begin
      quot_d  = dividend_i;
      rem_d   = '0;
      dvsr_d  = divisor_i;
      cnt_d   = CntW'(WIDTH);
      busy_d  = 1'b1;
      valid_d = 1'b0;
      dbz_d   = (divisor_i == '0);
    end else if (busy_q) begin
      quot_d = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
      rem_d  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      cnt_d  = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
    end
  end

  assign done_o  = done_q;
  assign valid_o = valid_q;
  assign dbz_o   = dbz_q;
  assign quot_o  = quot_q;
  assign rem_o   = rem_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// DIV/DIVU/REM/REMU sequencer around divu_int: sign handling, ISA special cases, kill.
// Optional result-reuse entry enabled by defining DIV_SEQ_REUSE_EN.
module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  div_seq_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH - 1){1'b0}}};

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             div_start, div_done, div_valid_unused, div_dbz_unused;
  logic [WIDTH-1:0] div_quot, div_rem, mag_a, mag_b, quot_post, rem_post, special_res;
  logic             req_signed, req_special;

  assign req_signed  = is_signed(bus.req_op);
  assign req_special = (bus.req_b == '0) ||
                       (req_signed && (bus.req_a == MinInt) && (bus.req_b == '1));

  always_comb begin
    if (bus.req_b == '0) begin
      special_res = is_rem(bus.req_op) ? bus.req_a : '1;
    end else begin
      special_res = is_rem(bus.req_op) ? '0 : MinInt;
    end
  end

  // Magnitude of MIN_INT wraps to 2^(WIDTH-1), which is the right unsigned value.
  assign mag_a     = (is_signed(op_q) && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed(op_q) && b_q[WIDTH-1]) ? -b_q : b_q;
  assign quot_post = (is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quot : div_quot;
  assign rem_post  = (is_signed(op_q) && a_q[WIDTH-1]) ? -div_rem : div_rem;

`ifdef DIV_SEQ_REUSE_EN
  logic             ent_valid_q, ent_valid_d, ent_signed_q, ent_signed_d, reuse_hit;
  logic [WIDTH-1:0] ent_a_q, ent_a_d, ent_b_q, ent_b_d;
  logic [WIDTH-1:0] ent_quot_q, ent_quot_d, ent_rem_q, ent_rem_d;

  assign reuse_hit = ent_valid_q && (bus.req_a == ent_a_q) && (bus.req_b == ent_b_q) &&
                     (req_signed == ent_signed_q);

  always_comb begin
    ent_valid_d  = ent_valid_q;
    ent_signed_d = ent_signed_q;
    ent_a_d      = ent_a_q;
    ent_b_d      = ent_b_q;
    ent_quot_d   = ent_quot_q;
    ent_rem_d    = ent_rem_q;
    if (bus.kill && ((state_q == START) || (state_q == WAIT))) begin
      ent_valid_d = 1'b0;
    end else if ((state_q == WAIT) && div_done) begin
      ent_valid_d  = 1'b1;
      ent_signed_d = is_signed(op_q);
      ent_a_d      = a_q;
      ent_b_d      = b_q;
      ent_quot_d   = quot_post;
      ent_rem_d    = rem_post;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_valid_q  <= 1'b0;
      ent_signed_q <= 1'b0;
      ent_a_q      <= '0;
      ent_b_q      <= '0;
      ent_quot_q   <= '0;
      ent_rem_q    <= '0;
    end else begin
      ent_valid_q  <= ent_valid_d;
      ent_signed_q <= ent_signed_d;
      ent_a_q      <= ent_a_d;
      ent_b_q      <= ent_b_d;
      ent_quot_q   <= ent_quot_d;
      ent_rem_q    <= ent_rem_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    div_start = 1'b0;
    if (bus.kill && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && !bus.kill) begin
            op_d = bus.req_op;
            a_d  = bus.req_a;
            b_d  = bus.req_b;
            if (req_special) begin
              res_d   = special_res;
              state_d = RESP;
            end
`ifdef DIV_SEQ_REUSE_EN
            else if (reuse_hit) begin
              res_d   = is_rem(bus.req_op) ? ent_rem_q : ent_quot_q;
              state_d = RESP;
            end
`endif
            else begin
              state_d = START;
            end
          end
        end
        START: begin
          div_start = 1'b1;
          state_d   = WAIT;
        end
        WAIT: begin
          if (div_done) begin
            res_d   = is_rem(op_q) ? rem_post : quot_post;
            state_d = RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= DIV;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = (state_q == RESP);
  assign bus.resp_result = res_q;

  divu_int #(
    .WIDTH(WIDTH)
  ) u_divu (
    .clk_i     (clk),
    .rst_ni    (rst),
    .start_i   (div_start),
    .dividend_i(mag_a),
    .divisor_i (mag_b),
    .done_o    (div_done),
    .valid_o   (div_valid_unused),
    .dbz_o     (div_dbz_unused),
    .quot_o    (div_quot),
    .rem_o     (div_rem)
  );

endmodule
